// File: rtl/stage_output_pkg.sv
// stage_output_pkg
// Shared opcode constants used by every pipeline stage of the Brainfuck core.
// The output stage only ever compares against OP_OUT. The remaining encodings
// are listed here so that all stages agree on a single opcode table.
package stage_output_pkg;

    localparam int OPCODE_MSB = 3;

    typedef logic [OPCODE_MSB:0] opcode_t;

    localparam opcode_t OP_NOP   = 4'h0;
    localparam opcode_t OP_INC   = 4'h1;   // +
    localparam opcode_t OP_DEC   = 4'h2;   // -
    localparam opcode_t OP_RIGHT = 4'h3;   // >
    localparam opcode_t OP_LEFT  = 4'h4;   // <
    localparam opcode_t OP_OUT   = 4'h5;   // .
    localparam opcode_t OP_IN    = 4'h6;   // ,
    localparam opcode_t OP_JZ    = 4'h7;   // [
    localparam opcode_t OP_JNZ   = 4'h8;   // ]
    localparam opcode_t OP_HALT  = 4'h9;

    // True for the only opcode that produces a byte for the sink.
    function automatic logic is_output_op(input opcode_t op);
        return op == OP_OUT;
    endfunction

endpackage

// File: rtl/stage_output_fifo.sv
// sync_fifo
// Single-clock FIFO built from a register file, with a combinational read of
// the head entry. It is reused for the output stage and is meant for a future
// input stage as well.
//   clk, reset : clock and synchronous active-high reset (pointers and
//                occupancy only; entry contents are not cleared)
//   push, din  : write din at the tail; ignored while full
//   pop        : discard the head entry; ignored while empty
//   dout       : head entry, valid whenever !empty
//   full/empty : occupancy == depth / occupancy == 0
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int OCC_W = DEPTH_LOG2 + 1;

    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]      occupancy_q, occupancy_d;
    logic [WIDTH-1:0]      entry_rd [DEPTH];

    logic push_en;
    logic pop_en;

    assign full    = (occupancy_q == OCC_W'(DEPTH));
    assign empty   = (occupancy_q == '0);
    // Guard internally so the FIFO stays consistent even if a caller ignores
    // full/empty. Pop is gated by the registered empty flag, which is what
    // keeps a byte written this cycle from being read out in the same cycle.
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occupancy_d = occupancy_q;
        if (push_en) begin
            wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
        end
        case ({push_en, pop_en})
            2'b10:   occupancy_d = occupancy_q + OCC_W'(1);
            2'b01:   occupancy_d = occupancy_q - OCC_W'(1);
            default: occupancy_d = occupancy_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occupancy_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occupancy_q <= occupancy_d;
        end
    end

    // One register per entry. Each entry loads only when it is the write
    // target, so stored bytes stay untouched until they are overwritten.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] entry_q, entry_d;

            always_comb begin
                entry_d = entry_q;
                if (push_en && (wr_ptr_q == DEPTH_LOG2'(gi))) begin
                    entry_d = din;
                end
            end

            always_ff @(posedge clk) begin
                entry_q <= entry_d;
            end

            assign entry_rd[gi] = entry_q;
        end
    endgenerate

    assign dout = entry_rd[rd_ptr_q];

endmodule

// File: rtl/stage_output.sv
// stage_output
// Last pipeline stage of the Brainfuck core. It retires every operation
// arriving from write-back and queues the cell byte of each '.' operation
// for an external byte sink. The sink stalls the pipeline only while the
// queue is full.
//   clk, reset            : clock and synchronous active-high reset
//   operation_in, data_in : retiring operation and its current cell byte
//   drdy_in / ack         : upstream valid / this stage accepts (combinational)
//   out_data, out_valid   : FIFO head byte and non-empty flag
//   out_ready             : sink accepts out_data this cycle
//   out_count             : bytes delivered to the sink since reset (wraps)
module stage_output
    import stage_output_pkg::*;
#(
    parameter int D_WIDTH     = 8,
    parameter int DEPTH_LOG2  = 2,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [OPCODE_MSB:0]    operation_in,
    input  logic [D_WIDTH-1:0]     data_in,
    input  logic                   drdy_in,
    output logic                   ack,
    output logic [D_WIDTH-1:0]     out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [COUNT_WIDTH-1:0] out_count
);

    logic is_out;
    logic fifo_push;
    logic fifo_pop;
    logic fifo_full;
    logic fifo_empty;

    logic [COUNT_WIDTH-1:0] out_count_q, out_count_d;

    // ack looks only at the FIFO's registered full flag. A pop in the same
    // cycle does not free a slot for the presented byte, which keeps ack off
    // any path from the sink's out_ready.
    assign is_out    = is_output_op(operation_in);
    assign ack       = !is_out || !fifo_full;
    assign fifo_push = drdy_in && is_out && !fifo_full;
    assign out_valid = !fifo_empty;
    assign fifo_pop  = out_valid && out_ready;

    sync_fifo #(
        .WIDTH      (D_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .din   (data_in),
        .pop   (fifo_pop),
        .dout  (out_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        out_count_d = out_count_q;
        if (fifo_pop) begin
            out_count_d = out_count_q + COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_count_q <= '0;
        end else begin
            out_count_q <= out_count_d;
        end
    end

    assign out_count = out_count_q;

endmodule

// File: tb/tb_stage_output.sv
module tb_stage_output;
    import stage_output_pkg::*;

    logic        clk;
    logic        reset;
    logic [3:0]  operation_in;
    logic [7:0]  data_in;
    logic        drdy_in;
    logic        ack;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_count;

    stage_output #(
        .D_WIDTH     (8),
        .DEPTH_LOG2  (2),
        .COUNT_WIDTH (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .operation_in (operation_in),
        .data_in      (data_in),
        .drdy_in      (drdy_in),
        .ack          (ack),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_count    (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One record per clock cycle: inputs driven after the falling edge,
    // expected outputs checked just before the following rising edge.
    typedef struct {
        bit       rst;
        bit [3:0] op;
        bit [7:0] din;
        bit       drdy;
        bit       rdy;
        bit       chk;
        bit       e_ack;
        bit       e_valid;
        bit [7:0] e_data;
        int       e_count;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit rst, input bit [3:0] op, input bit [7:0] din,
                       input bit drdy, input bit rdy, input bit chk,
                       input bit e_ack, input bit e_valid, input bit [7:0] e_data,
                       input int e_count);
        vec_t v;
        v.rst = rst; v.op = op; v.din = din; v.drdy = drdy; v.rdy = rdy;
        v.chk = chk; v.e_ack = e_ack; v.e_valid = e_valid; v.e_data = e_data;
        v.e_count = e_count;
        vecs.push_back(v);
    endtask

    initial begin
        reset        = 1'b1;
        operation_in = OP_OUT;
        data_in      = 8'h55;
        drdy_in      = 1'b1;
        out_ready    = 1'b1;

        //   rst op      din    drdy rdy chk ack val data   cnt
        // reset for 2 cycles with OP_OUT presented
        add(1, OP_OUT, 8'h55, 1, 1, 0, 1, 0, 8'h00, 0);
        add(1, OP_OUT, 8'h55, 1, 1, 1, 1, 0, 8'h00, 0);
        add(0, OP_OUT, 8'h66, 0, 1, 1, 1, 0, 8'h00, 0);
        // single byte
        add(0, OP_OUT, 8'h48, 1, 1, 1, 1, 0, 8'h00, 0);
        add(0, OP_NOP, 8'h00, 0, 1, 1, 1, 1, 8'h48, 0);
        add(0, OP_NOP, 8'h00, 0, 1, 1, 1, 0, 8'h00, 1);
        // backpressure fills the FIFO
        add(0, OP_OUT, 8'h01, 1, 0, 1, 1, 0, 8'h00, 1);
        add(0, OP_OUT, 8'h02, 1, 0, 1, 1, 1, 8'h01, 1);
        add(0, OP_OUT, 8'h03, 1, 0, 1, 1, 1, 8'h01, 1);
        add(0, OP_OUT, 8'h04, 1, 0, 1, 1, 1, 8'h01, 1);
        add(0, OP_OUT, 8'h05, 1, 0, 1, 0, 1, 8'h01, 1);
        add(0, OP_INC, 8'h00, 1, 0, 1, 1, 1, 8'h01, 1);
        // full with sink ready: no same-cycle bypass, push lands next cycle
        add(0, OP_OUT, 8'h05, 1, 1, 1, 0, 1, 8'h01, 1);
        add(0, OP_OUT, 8'h05, 1, 0, 1, 1, 1, 8'h02, 2);
        add(0, OP_NOP, 8'h00, 0, 1, 1, 1, 1, 8'h02, 2);
        add(0, OP_NOP, 8'h00, 0, 1, 1, 1, 1, 8'h03, 3);
        add(0, OP_NOP, 8'h00, 0, 1, 1, 1, 1, 8'h04, 4);
        add(0, OP_NOP, 8'h00, 0, 1, 1, 1, 1, 8'h05, 5);
        add(0, OP_NOP, 8'h00, 0, 1, 1, 1, 0, 8'h00, 6);
        // reset mid-stream with three bytes buffered
        add(0, OP_OUT, 8'h11, 1, 0, 1, 1, 0, 8'h00, 6);
        add(0, OP_OUT, 8'h22, 1, 0, 1, 1, 1, 8'h11, 6);
        add(0, OP_OUT, 8'h33, 1, 0, 1, 1, 1, 8'h11, 6);
        add(1, OP_OUT, 8'h44, 1, 1, 1, 1, 1, 8'h11, 6);
        add(0, OP_OUT, 8'h7E, 1, 0, 1, 1, 0, 8'h00, 0);
        add(0, OP_NOP, 8'h00, 0, 0, 1, 1, 1, 8'h7E, 0);
        add(0, OP_NOP, 8'h00, 0, 1, 1, 1, 1, 8'h7E, 0);
        add(0, OP_NOP, 8'h00, 0, 0, 1, 1, 0, 8'h00, 1);

        foreach (vecs[i]) begin
            @(negedge clk);
            reset        = vecs[i].rst;
            operation_in = vecs[i].op;
            data_in      = vecs[i].din;
            drdy_in      = vecs[i].drdy;
            out_ready    = vecs[i].rdy;
            #1;
            if (vecs[i].chk) begin
                check($sformatf("v%0d.ack", i), int'(ack), int'(vecs[i].e_ack));
                check($sformatf("v%0d.valid", i), int'(out_valid), int'(vecs[i].e_valid));
                if (vecs[i].e_valid)
                    check($sformatf("v%0d.data", i), int'(out_data), int'(vecs[i].e_data));
                check($sformatf("v%0d.count", i), int'(out_count), vecs[i].e_count);
                $display("vec %0d: ack=%0b valid=%0b data=%02h count=%0d",
                         i, ack, out_valid, out_data, out_count);
            end
        end

        // Wrap-around: ten bytes A0..A9 pushed back to back while the sink
        // alternates ready/not-ready, checked against a queue model.
        begin
            bit [7:0] q[$];
            int       n_pushed    = 0;
            int       n_delivered = 0;
            int       exp_count   = 1;
            bit       done        = 0;
            bit       exp_ack;
            for (int cyc = 0; cyc < 80 && !done; cyc++) begin
                @(negedge clk);
                reset        = 1'b0;
                out_ready    = (cyc % 2 == 0);
                drdy_in      = (n_pushed < 10);
                operation_in = (n_pushed < 10) ? OP_OUT : OP_NOP;
                data_in      = 8'hA0 + 8'(n_pushed);
                #1;
                exp_ack = (operation_in != OP_OUT) || (q.size() < 4);
                check($sformatf("wrap%0d.ack", cyc), int'(ack), int'(exp_ack));
                check($sformatf("wrap%0d.valid", cyc), int'(out_valid), int'(q.size() != 0));
                if (q.size() != 0)
                    check($sformatf("wrap%0d.data", cyc), int'(out_data), int'(q[0]));
                check($sformatf("wrap%0d.count", cyc), int'(out_count), exp_count);
                if (q.size() != 0 && out_ready) begin
                    $display("wrap pop %02h", q[0]);
                    void'(q.pop_front());
                    exp_count++;
                    n_delivered++;
                end
                if (drdy_in && operation_in == OP_OUT && exp_ack) begin
                    $display("wrap push %02h", data_in);
                    q.push_back(data_in);
                    n_pushed++;
                end
                if (n_delivered == 10) done = 1;
            end
            check("wrap.done", int'(done), 1);
            @(negedge clk);
            drdy_in   = 1'b0;
            out_ready = 1'b0;
            #1;
            check("wrap.final_count", int'(out_count), 11);
            check("wrap.final_valid", int'(out_valid), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
